rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-way round-robin arbiter that shares one resource among up to eight requesters. It produces a one-hot grant vector, the one-hot form of a registered 3-bit grant index, together with the index itself. The arbiter holds each grant until the owner releases it or a hold-timeout expires. It sits in front of any shared datapath whose select lines are driven by the 3-to-8 one-hot decode in this codebase.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held. 0 disables the timeout. Legal range 0..255.
- `clk_i` input 1: clock. All logic is on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_i` input 8: request per requester. Bit k belongs to requester k.
- `done_i` input 1: the current owner releases the grant. Sampled only in GRANT.
- `gnt_o` output 8: one-hot grant. All zero when no grant is held.
- `gnt_idx_o` output 3: binary index of the current owner. Holds its last value when idle.
- `gnt_valid_o` output 1: a grant is held. Equal to OR of `gnt_o`.
- `timeout_o` output 1: one-cycle pulse when a grant is forcibly revoked by timeout.

## Operation
- Two-state FSM: IDLE, GRANT. All outputs are registered.
- Priority pointer `ptr` (3 bits) holds the requester with highest priority. The search order is ptr, ptr+1, …, ptr+7, mod 8.
- IDLE:
  - If `req_i` != 0, select the first set bit in search order as winner w.
  - On the next edge: go to GRANT, `gnt_idx_o`=w, `gnt_o`=1<<w, `gnt_valid_o`=1, hold counter=0.
  - If `req_i`==0, stay in IDLE.
- GRANT:
  - The hold counter increments each cycle (8 bits).
  - Release occurs on `done_i`=1 **or** `req_i[gnt_idx_o]`=0.
  - On release, the next edge sets: IDLE, `gnt_o`=0, `gnt_valid_o`=0, `ptr`=gnt_idx_o+1 mod 8 (wraps 7→0).
- Timeout: if `MAX_HOLD`!=0, there is no release condition, and counter == MAX_HOLD-1, the next edge performs the same release and sets `timeout_o`=1 for exactly that one cycle.
- Release and timeout in the same cycle count as a normal release; `timeout_o` stays 0.
- `done_i` in IDLE is ignored.
- Requests other than the owner's are ignored during GRANT. They do not preempt the owner.
- The arbiter never grants two requesters at once. `gnt_o` is always zero or one-hot.
- Fairness: any requester whose request stays asserted is granted within 8 grant cycles.

## Timing
- Reset values: `gnt_o`=8'h00, `gnt_idx_o`=3'd0, `gnt_valid_o`=0, `timeout_o`=0, `ptr`=0, state IDLE, counter 0.
- Reset mid-grant: the grant is dropped at the edge where `rst_i` is sampled high, and `ptr` returns to 0.
- Request-to-grant latency: `req_i` sampled in IDLE at edge N; `gnt_o` is valid after edge N.
- Release-to-deassert latency: release condition sampled at edge M; `gnt_o`=0 after edge M.
- There is a mandatory one-cycle IDLE bubble between consecutive grants. Peak rate is one grant per 2 cycles.
- With a grant starting at edge N and no release, `timeout_o` is high and `gnt_o` is 0 after edge N+MAX_HOLD. The grant is therefore visible for exactly MAX_HOLD cycles.
- Combinational paths from inputs to outputs: none.

## Test plan
- Reset then single request:
  - Stimulus: `rst_i`=1 for 2 cycles, check all outputs 0. Then `req_i`=8'h10.
  - Required: `gnt_o`=8'h10, `gnt_idx_o`=4 one cycle later. `done_i` pulse → `gnt_o`=0 next cycle, ptr=5.
- Round-robin rotation:
  - Stimulus: `req_i`=8'hFF held, `done_i` pulsed on each grant's first cycle.
  - Required: grant indices 0,1,2,…,7,0 in order, with one idle cycle between each grant.
- Pointer wrap:
  - Stimulus: grant 7 then release, `req_i`=8'h81.
  - Required: next grant is index 0, not 7. Then grant 7 again.
- Timeout, `MAX_HOLD`=4:
  - Stimulus: `req_i`=8'h04 held, `done_i`=0.
  - Required: `gnt_o`=8'h04 for 4 cycles, then `gnt_o`=0 with `timeout_o`=1 for one cycle, then re-grant index 2.
  - Stimulus: `done_i`=1 on the 4th grant cycle.
  - Required: `timeout_o` stays 0.
- Request drop and non-preemption:
  - Stimulus: owner 3 granted, `req_i` changes to 8'h01 (owner drops, requester 0 rises).
  - Required: release next cycle, then grant index 0 after the bubble. Requester 0 is never granted while 3 holds.
- Reset mid-grant:
  - Stimulus: owner 6 holding, `rst_i`=1 for one cycle with `req_i`=8'h41.
  - Required: outputs 0 after that edge. The first grant after reset is index 0 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
//   Eight-way round-robin arbiter. One requester at a time owns the shared
//   resource until it releases it (done_i or request drop) or, when MAX_HOLD
//   is non-zero, until the hold timeout revokes it. After every release the
//   priority pointer moves to the requester just after the previous owner.
//
// Parameters
//   MAX_HOLD     maximum grant length in cycles, 0 disables the timeout (0..255)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i[7:0]   request per requester, bit k = requester k
//   done_i       owner releases the grant (only looked at while granting)
//   gnt_o[7:0]   registered one-hot grant, zero when idle
//   gnt_idx_o    registered binary index of the owner, holds when idle
//   gnt_valid_o  registered "grant held" flag
//   timeout_o    one-cycle pulse when a grant is revoked by timeout
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       timeout_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter value seen in the last cycle a grant may be held.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam bit         HOLD_EN   = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        win_found;
    logic        release_c;
    logic        timeout_hit;

    // Winner search: rotate the requests so the pointer position lands on bit
    // 0, take the lowest set bit, then add the pointer back.
    always_comb begin
        req_dbl   = {req_i, req_i};
        req_rot   = req_dbl[ptr_q +: 8];
        win_found = |req_rot;
        win_off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        win_idx = ptr_q + win_off;
    end

    // Owner releases voluntarily; a simultaneous timeout is treated as a
    // normal release, so the timeout only fires without a release.
    always_comb begin
        release_c   = done_i | ~req_i[gnt_idx_q];
        timeout_hit = HOLD_EN && (cnt_q == HOLD_LAST) && !release_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            cnt_q       <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_c || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d       = 8'b1 << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = 8'd0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 8'd1;
                if (release_c || timeout_hit) begin
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    // 3-bit add wraps 7 -> 0.
                    ptr_d       = gnt_idx_q + 3'd1;
                    timeout_d   = timeout_hit;
                end
            end
            default: begin
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] req_i = 8'h00;
    logic       done_i = 1'b0;

    logic [7:0] g4, g0;
    logic [2:0] i4, i0;
    logic       v4, v0, t4, t0;

    rr_arbiter_8 #(.MAX_HOLD(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
        .gnt_o(g4), .gnt_idx_o(i4), .gnt_valid_o(v4), .timeout_o(t4)
    );

    rr_arbiter_8 #(.MAX_HOLD(0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
        .gnt_o(g0), .gnt_idx_o(i0), .gnt_valid_o(v0), .timeout_o(t0)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       busy;
        logic [2:0] ptr;
        logic [7:0] cnt;
        logic [2:0] idx;
        logic       to;
    } mstate_t;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } exp_t;

    mstate_t m4 = '0;
    mstate_t m0 = '0;
    exp_t    exp_q[$];
    int      n_chk  = 0;
    int      n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: one clock edge of an arbiter with hold limit mh.
    function automatic mstate_t mstep(mstate_t s, logic rst, logic [7:0] req,
                                      logic done, int mh);
        mstate_t    n;
        logic [2:0] j;
        bit         found;
        bit         rel;
        bit         tmo;
        n    = s;
        n.to = 1'b0;
        if (rst) begin
            n = '0;
            return n;
        end
        if (!s.busy) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                j = s.ptr + 3'(k);
                if (!found && req[j]) begin
                    found  = 1;
                    n.busy = 1'b1;
                    n.idx  = j;
                    n.cnt  = 8'd0;
                end
            end
        end else begin
            rel = done || !req[s.idx];
            tmo = (mh != 0) && (int'(s.cnt) + 1 == mh);
            if (rel || tmo) begin
                n.busy = 1'b0;
                n.ptr  = s.idx + 3'd1;
                n.to   = !rel;
            end else begin
                n.cnt = s.cnt + 8'd1;
            end
        end
        return n;
    endfunction

    function automatic exp_t mout(mstate_t s);
        exp_t e;
        e.gnt = s.busy ? (8'b1 << s.idx) : 8'h00;
        e.idx = s.idx;
        e.v   = s.busy;
        e.to  = s.to;
        return e;
    endfunction

    task automatic cmp_one(input string tag, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_gnt"}, 32'(g), 32'(e.gnt));
        chk({tag, "_idx"}, 32'(i), 32'(e.idx));
        chk({tag, "_valid"}, 32'(v), 32'(e.v));
        chk({tag, "_timeout"}, 32'(t), 32'(e.to));
        chk({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
        chk({tag, "_valid_or"}, 32'(v), 32'(|g));
    endtask

    // Drive one cycle of inputs, predict at the edge, compare after it.
    task automatic cycle(input logic rst, input logic [7:0] req, input logic done);
        rst_i  = rst;
        req_i  = req;
        done_i = done;
        @(posedge clk_i);
        m4 = mstep(m4, rst, req, done, 4);
        m0 = mstep(m0, rst, req, done, 0);
        exp_q.push_back(mout(m4));
        exp_q.push_back(mout(m0));
        #1;
        cmp_one("h4", g4, i4, v4, t4);
        cmp_one("h0", g0, i0, v0, t0);
    endtask

    int got_q[$];
    int to_cnt;

    initial begin
        // Reset then single request
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        chk("rst_gnt", 32'(g4), 32'h00);
        chk("rst_idx", 32'(i4), 32'd0);
        cycle(1'b0, 8'h10, 1'b0);
        chk("single_gnt", 32'(g4), 32'h10);
        chk("single_idx", 32'(i4), 32'd4);
        cycle(1'b0, 8'h10, 1'b1);
        chk("single_rel", 32'(g4), 32'h00);
        cycle(1'b0, 8'h00, 1'b1);               // done in IDLE is ignored
        cycle(1'b0, 8'h30, 1'b0);               // ptr=5 must prefer 5 over 4
        chk("ptr5_idx", 32'(i4), 32'd5);
        cycle(1'b0, 8'h30, 1'b1);

        // Round-robin rotation
        cycle(1'b1, 8'h00, 1'b0);
        got_q.delete();
        for (int n = 0; n < 18; n++) begin
            cycle(1'b0, 8'hFF, v4);
            if (v4) got_q.push_back(int'(i4));
        end
        chk("rot_count", 32'(got_q.size()), 32'd9);
        for (int n = 0; n < got_q.size(); n++) begin
            chk("rot_order", 32'(got_q[n]), 32'(n % 8));
        end
        cycle(1'b0, 8'h00, 1'b0);

        // Pointer wrap
        cycle(1'b0, 8'h80, 1'b0);
        chk("wrap_g7", 32'(i4), 32'd7);
        cycle(1'b0, 8'h80, 1'b1);
        cycle(1'b0, 8'h81, 1'b0);
        chk("wrap_g0", 32'(g4), 32'h01);
        cycle(1'b0, 8'h81, 1'b1);
        cycle(1'b0, 8'h81, 1'b0);
        chk("wrap_g7b", 32'(g4), 32'h80);
        cycle(1'b0, 8'h81, 1'b1);

        // Timeout with held request
        cycle(1'b1, 8'h00, 1'b0);
        to_cnt = 0;
        for (int n = 0; n < 14; n++) begin
            cycle(1'b0, 8'h04, 1'b0);
            if (t4) to_cnt++;
        end
        chk("to_pulses", 32'(to_cnt), 32'd2);
        chk("to_hold_forever", 32'(g0), 32'h04);
        // done on the 4th grant cycle: normal release, no timeout pulse
        cycle(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 4; n++) cycle(1'b0, 8'h04, 1'b0);
        chk("to_4th_gnt", 32'(g4), 32'h04);
        cycle(1'b0, 8'h04, 1'b1);
        chk("to_done_gnt", 32'(g4), 32'h00);
        chk("to_done_pulse", 32'(t4), 32'd0);

        // Request drop and non-preemption
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h08, 1'b0);
        chk("drop_g3", 32'(i4), 32'd3);
        cycle(1'b0, 8'h09, 1'b0);
        chk("nopreempt", 32'(g4), 32'h08);
        cycle(1'b0, 8'h01, 1'b0);
        chk("drop_rel", 32'(g4), 32'h00);
        cycle(1'b0, 8'h01, 1'b0);
        chk("drop_g0", 32'(g4), 32'h01);
        cycle(1'b0, 8'h00, 1'b0);

        // Reset mid-grant
        cycle(1'b0, 8'h40, 1'b0);
        chk("mid_g6", 32'(i4), 32'd6);
        cycle(1'b1, 8'h41, 1'b0);
        chk("mid_rst_gnt", 32'(g4), 32'h00);
        cycle(1'b0, 8'h41, 1'b0);
        chk("mid_first_g0", 32'(g4), 32'h01);

        // Random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  8'($urandom()) & 8'($urandom()),
                  ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
